sound_glu_ram_reader: RTL and testbench

Read-side companion to the GLU sound-RAM write path: services CPU reads of the Sound Data register ($C03D) when the Sound Control register selects RAM access. It reproduces the IIgs one-behind read semantics. A read returns the byte latched by the previous fetch and starts a new 32-bit SDRAM fetch at the current sound pointer. It sits beside the GLU register file, drives a read-only SDRAM client port into the 64K DOC RAM window (word base 0x1_0000), and requests pointer auto-increment.

---
 rtl/sound_glu_pkg.sv | 32 +++
 rtl/sound_glu_ram_reader.sv | 124 ++++++++++++
 tb/tb_sound_glu_ram_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_glu_pkg.sv
// Shared constants and types for the GLU sound block: DOC RAM window base,
// sound register addresses and the RAM reader state encoding.
package sound_glu_pkg;

    // Upper seven bits of the 21-bit SDRAM word address selecting the 64K DOC RAM window.
    localparam logic [6:0] DOC_RAM_WORD_BASE = 7'b0000100;

    typedef enum logic [15:0] {
        REG_SOUND_CTL    = 16'hC03C,
        REG_SOUND_DATA   = 16'hC03D,
        REG_SOUND_PTR_LO = 16'hC03E,
        REG_SOUND_PTR_HI = 16'hC03F
    } sound_reg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } rd_state_t;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sound_glu_ram_reader.sv
// Sound Data register read path into DOC RAM with IIgs one-behind semantics.
// Build option: SOUND_GLU_RD_PREFETCH_EN makes pointer writes prefetch the new byte.
module sound_glu_ram_reader
    import sound_glu_pkg::*;
#(
    parameter logic        ENABLE         = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_logic,
    input  logic        system_reset,
    input  logic        rd_strobe_i,
    input  logic        wr_strobe_i,
    input  logic [7:0]  wr_data_i,
    input  logic [15:0] ptr_i,
    input  logic        auto_inc_i,
    input  logic        ptr_wr_i,
    output logic [7:0]  data_o,
    output logic        ptr_inc_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        mem_rd_o,
    output logic [20:0] mem_addr_o,
    output logic [3:0]  mem_byte_en_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_q_i,
    output rd_state_t   dbg_state_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    rd_state_t   state_r, state_nxt;
    logic [15:0] fetch_ptr_r, pend_ptr_r;
    logic        pending_r, cancel_r, err_r;
    logic [7:0]  data_r, wait_cnt_r;

    logic rd_fire, wr_fire, pf_fire, trig;
    logic in_wait, timeout, done, can_launch;
    logic launch_pend, launch_new, launch, slot_free, queue_new, drop;

    // A simultaneous CPU write takes the cycle: the read neither fetches nor increments.
    assign rd_fire = ENABLE && rd_strobe_i && !wr_strobe_i && !system_reset;
    assign wr_fire = ENABLE && wr_strobe_i;

`ifdef SOUND_GLU_RD_PREFETCH_EN
    assign pf_fire = ENABLE && ptr_wr_i && !system_reset;
`else
    logic unused_ptr_wr;
    assign unused_ptr_wr = ptr_wr_i;
    assign pf_fire       = 1'b0;
`endif

    assign trig        = rd_fire || pf_fire;
    assign in_wait     = (state_r == WAIT);
    assign timeout     = in_wait && !mem_ready_i && (wait_cnt_r == TIMEOUT_LAST);
    assign done        = in_wait && (mem_ready_i || timeout);
    // A queued fetch goes straight from the completing WAIT into REQ.
    assign can_launch  = (state_r == IDLE) || done;
    assign launch_pend = can_launch && pending_r;
    assign launch_new  = can_launch && !pending_r && trig;
    assign launch      = launch_pend || launch_new;
    assign slot_free   = !pending_r || launch_pend;
    assign queue_new   = trig && !launch_new && slot_free;
    assign drop        = trig && !launch_new && !slot_free;

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE:    if (launch) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    if (done) state_nxt = launch ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            state_r     <= IDLE;
            fetch_ptr_r <= 16'h0000;
            pend_ptr_r  <= 16'h0000;
            pending_r   <= 1'b0;
            cancel_r    <= 1'b0;
            err_r       <= 1'b0;
            data_r      <= 8'h00;
            wait_cnt_r  <= 8'h00;
        end else begin
            state_r <= state_nxt;
            if (launch)
                fetch_ptr_r <= launch_pend ? pend_ptr_r : ptr_i;
            if (queue_new) begin
                pending_r  <= 1'b1;
                pend_ptr_r <= ptr_i;
            end else if (launch_pend) begin
                pending_r <= 1'b0;
            end
            if (state_r == REQ)
                wait_cnt_r <= 8'h00;
            else if (in_wait)
                wait_cnt_r <= wait_cnt_r + 8'h01;
            // A CPU write during an outstanding fetch wins over its late result.
            if (done)
                cancel_r <= 1'b0;
            else if (wr_fire && state_r != IDLE)
                cancel_r <= 1'b1;
            if (wr_fire)
                data_r <= wr_data_i;
            else if (in_wait && mem_ready_i && !cancel_r)
                data_r <= byte_lane(mem_q_i, fetch_ptr_r[1:0]);
            if (timeout || drop)
                err_r <= 1'b1;
        end
    end

    // Memory handshake: mem_rd_o is a one-cycle request whose mem_addr_o holds
    // until the response; mem_ready_i is honoured only in WAIT, so strays are dropped.
    assign mem_rd_o      = (state_r == REQ);
    assign mem_addr_o    = {DOC_RAM_WORD_BASE, fetch_ptr_r[15:2]};
    assign mem_byte_en_o = 4'b1111;
    assign busy_o        = (state_r != IDLE);
    assign ptr_inc_o     = rd_fire && auto_inc_i;
    assign data_o        = data_r;
    assign err_o         = err_r;
    assign dbg_state_o   = state_r;

endmodule

// File: tb/tb_sound_glu_ram_reader.sv
// Directed bench for sound_glu_ram_reader with address/data expectation queues.
module tb_sound_glu_ram_reader;
  import sound_glu_pkg::*;

  localparam int TMO = 8;

  logic        clk;
  logic        system_reset;
  logic        rd_strobe_i, wr_strobe_i, auto_inc_i, ptr_wr_i, mem_ready_i;
  logic [7:0]  wr_data_i;
  logic [15:0] ptr_i;
  logic [31:0] mem_q_i;
  logic [7:0]  data_o;
  logic        ptr_inc_o, busy_o, err_o, mem_rd_o;
  logic [20:0] mem_addr_o;
  logic [3:0]  mem_byte_en_o;
  rd_state_t   dbg_state;

  logic [20:0] exp_addr_q[$];
  logic [7:0]  exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_inc_seen = 0;
  int n_inc_exp = 0;
  int n_fetch_seen = 0;
  int n_fetch_exp = 0;
  bit prev_rd = 1'b0;

  sound_glu_ram_reader #(.ENABLE(1'b1), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_logic(clk), .system_reset(system_reset),
    .rd_strobe_i(rd_strobe_i), .wr_strobe_i(wr_strobe_i), .wr_data_i(wr_data_i),
    .ptr_i(ptr_i), .auto_inc_i(auto_inc_i), .ptr_wr_i(ptr_wr_i),
    .data_o(data_o), .ptr_inc_o(ptr_inc_o), .busy_o(busy_o), .err_o(err_o),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_ready_i(mem_ready_i), .mem_q_i(mem_q_i), .dbg_state_o(dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic do_reset();
    system_reset = 1'b1;
    rd_strobe_i = 1'b0; wr_strobe_i = 1'b0; ptr_wr_i = 1'b0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 system_reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd(input bit expect_fetch, input logic [7:0] exp_ret);
    rd_strobe_i = 1'b1;
    if (expect_fetch) begin
      exp_addr_q.push_back({4'b0, 1'b1, 2'b0, ptr_i[15:2]});
      n_fetch_exp++;
    end
    @(negedge clk);
    check("ptr_inc_at_read", ptr_inc_o, auto_inc_i);
    check("data_one_behind", data_o, exp_ret);
    if (auto_inc_i) n_inc_exp++;
    step(1);
    rd_strobe_i = 1'b0;
    if (auto_inc_i) ptr_i = ptr_i + 16'd1;
  endtask

  task automatic pulse_ready(input logic [31:0] word, input logic [7:0] exp_data);
    mem_q_i = word;
    exp_q.push_back(exp_data);
    mem_ready_i = 1'b1;
    step(1);
    mem_ready_i = 1'b0;
  endtask

  task automatic check_data(input string tag);
    logic [7:0] e;
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, data_o, e);
  endtask

  task automatic do_fetch(input logic [7:0] exp_ret, input logic [31:0] word, input logic [7:0] exp_new);
    pulse_rd(1'b1, exp_ret);
    @(negedge clk);
    check("busy_in_req", busy_o, 1'b1);
    check("state_req", dbg_state, REQ);
    step(1);
    @(negedge clk);
    check("state_wait", dbg_state, WAIT);
    step(1);
    pulse_ready(word, exp_new);
    check_data("fetched_byte");
    check("busy_after_ready", busy_o, 1'b0);
  endtask

  // scoreboard: every memory request is matched against the expected address queue
  always @(negedge clk) begin
    if (ptr_inc_o) n_inc_seen++;
    if (mem_rd_o) begin
      n_fetch_seen++;
      check("mem_rd_single_cycle", prev_rd, 1'b0);
      check("mem_byte_en", mem_byte_en_o, 4'hF);
      check("mem_rd_expected", exp_addr_q.size() != 0, 1'b1);
      if (exp_addr_q.size() != 0) check("mem_addr", mem_addr_o, exp_addr_q.pop_front());
    end
    prev_rd = mem_rd_o;
  end

  initial begin
    system_reset = 1'b1;
    rd_strobe_i = 1'b0; wr_strobe_i = 1'b0; wr_data_i = 8'h00; ptr_i = 16'h0000;
    auto_inc_i = 1'b0; ptr_wr_i = 1'b0; mem_ready_i = 1'b0; mem_q_i = 32'h0;
    do_reset();
    @(negedge clk);
    check("rst_data", data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_mem_rd", mem_rd_o, 1'b0);
    check("rst_ptr_inc", ptr_inc_o, 1'b0);
    check("rst_addr", mem_addr_o, 21'h010000);
    check("rst_state", dbg_state, IDLE);
    step(1);

    // basic fetch: 0x1235 -> word 0x048D, lane 1
    ptr_i = 16'h1235;
    do_fetch(8'h00, 32'hDDCCBBAA, 8'hBB);
    step(2);

    // auto-increment, two reads about 20 cycles apart
    auto_inc_i = 1'b1;
    ptr_i = 16'h1237;
    do_fetch(8'hBB, 32'h44332211, 8'h44);
    step(14);
    do_fetch(8'h44, 32'h88776655, 8'h55);
    check("ptr_after_two_reads", ptr_i, 16'h1239);
    step(2);

    // write during WAIT cancels the fetch result
    auto_inc_i = 1'b0;
    ptr_i = 16'h1240;
    pulse_rd(1'b1, 8'h55);
    step(1);
    wr_strobe_i = 1'b1; wr_data_i = 8'h5A;
    step(1);
    wr_strobe_i = 1'b0;
    @(negedge clk);
    check("wr_data_loaded", data_o, 8'h5A);
    check("wr_state_wait", dbg_state, WAIT);
    step(1);
    pulse_ready(32'h11223377, 8'h5A);
    check_data("cancelled_fetch");
    check("cancel_busy", busy_o, 1'b0);
    step(2);

    // three reads while the first is outstanding
    auto_inc_i = 1'b1;
    ptr_i = 16'h2003;
    pulse_rd(1'b1, 8'h5A);
    pulse_rd(1'b1, 8'h5A);
    pulse_rd(1'b0, 8'h5A);
    @(negedge clk);
    check("overrun_err", err_o, 1'b1);
    check("overrun_busy", busy_o, 1'b1);
    check("overrun_state", dbg_state, WAIT);
    step(1);
    pulse_ready(32'hA3A2A1A0, 8'hA3);
    check_data("first_of_three");
    check("pending_req_next", dbg_state, REQ);
    check("pending_busy", busy_o, 1'b1);
    step(1);
    pulse_ready(32'hB3B2B1B0, 8'hB0);
    check_data("second_of_three");
    check("three_idle", dbg_state, IDLE);
    check("three_inc_count", n_inc_seen, n_inc_exp);
    step(2);

    // timeout, then a stray ready
    auto_inc_i = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst2_err", err_o, 1'b0);
    check("rst2_data", data_o, 8'h00);
    step(1);
    wr_strobe_i = 1'b1; wr_data_i = 8'hC3;
    step(1);
    wr_strobe_i = 1'b0;
    @(negedge clk);
    check("wr_idle", data_o, 8'hC3);
    step(1);
    ptr_i = 16'h3000;
    pulse_rd(1'b1, 8'hC3);
    step(TMO);
    @(negedge clk);
    check("tmo_last_wait", dbg_state, WAIT);
    check("tmo_err_before", err_o, 1'b0);
    step(1);
    @(negedge clk);
    check("tmo_state_idle", dbg_state, IDLE);
    check("tmo_err", err_o, 1'b1);
    check("tmo_data", data_o, 8'hC3);
    step(1);
    pulse_ready(32'hFFFFFFFF, 8'hC3);
    check_data("stray_ready");
    check("stray_busy", busy_o, 1'b0);
    step(1);

    // read and write together: write wins, read ignored
    auto_inc_i = 1'b1;
    rd_strobe_i = 1'b1; wr_strobe_i = 1'b1; wr_data_i = 8'h3C;
    @(negedge clk);
    check("rdwr_no_inc", ptr_inc_o, 1'b0);
    step(1);
    rd_strobe_i = 1'b0; wr_strobe_i = 1'b0;
    @(negedge clk);
    check("rdwr_data", data_o, 8'h3C);
    check("rdwr_state", dbg_state, IDLE);
    step(3);

    // reset mid-fetch, late ready ignored
    auto_inc_i = 1'b0;
    ptr_i = 16'h0004;
    pulse_rd(1'b1, 8'h3C);
    step(1);
    do_reset();
    pulse_ready(32'h99999999, 8'h00);
    check_data("late_ready_after_reset");
    check("late_ready_state", dbg_state, IDLE);
    step(1);

    // pointer write prefetch
    auto_inc_i = 1'b1;
    ptr_i = 16'h0010;
    ptr_wr_i = 1'b1;
`ifdef SOUND_GLU_RD_PREFETCH_EN
    exp_addr_q.push_back({4'b0, 1'b1, 2'b0, ptr_i[15:2]});
    n_fetch_exp++;
`endif
    @(negedge clk);
    check("ptr_wr_no_inc", ptr_inc_o, 1'b0);
    step(1);
    ptr_wr_i = 1'b0;
`ifdef SOUND_GLU_RD_PREFETCH_EN
    @(negedge clk);
    check("prefetch_req", dbg_state, REQ);
    step(2);
    pulse_ready(32'h00000042, 8'h42);
    check_data("prefetch_byte");
    step(1);
    do_fetch(8'h42, 32'h00000042, 8'h42);
`else
    step(2);
    @(negedge clk);
    check("no_prefetch_idle", dbg_state, IDLE);
    check("no_prefetch_busy", busy_o, 1'b0);
    step(1);
    do_fetch(8'h00, 32'h00000042, 8'h42);
`endif
    step(3);

    // final report
    check("inc_pulse_total", n_inc_seen, n_inc_exp);
    check("fetch_total", n_fetch_seen, n_fetch_exp);
    check("addr_queue_drained", exp_addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
